// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter for the single-port data RAM, with a bounded
// master-1 bus lock and out-of-range address protection.
module ram_arbiter #(
  parameter int LEN      = 1024,
  parameter int MAX_LOCK = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] ram_A,
  output logic [31:0] ram_D,
  output logic        ram_WE,
  input  logic [31:0] ram_Q
);

  // Handshake: a master holds req and its fields stable until gnt; gnt is
  // combinational in the request cycle and rvalid pulses exactly one cycle later.
  localparam int CW = $clog2(MAX_LOCK) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOCK);
  localparam logic [31:0]   LEN_W   = 32'(LEN);

  typedef enum logic {ARB, LOCK1} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in0, in1;

  // Full 32-bit comparison so high addresses never alias into the RAM.
  assign in0 = (m0_addr < LEN_W);
  assign in1 = (m1_addr < LEN_W);

  always_comb begin
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (!RST) begin
      case (state_q)
        ARB: begin
          if (m0_req && m1_req) begin
            m0_gnt = last_q;
            m1_gnt = !last_q;
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
          if (m1_gnt && m1_lock) begin
            state_d = LOCK1;
            cnt_d   = CW'(1);
          end
        end
        LOCK1: begin
          if (!m1_lock) begin
            m1_gnt  = m1_req;
            state_d = ARB;
            cnt_d   = '0;
          end else if (cnt_q == MAX_CNT) begin
            // Forced release: nobody granted, master 0 favoured next cycle.
            state_d = ARB;
            cnt_d   = '0;
            last_d  = 1'b1;
          end else begin
            m1_gnt = m1_req;
            cnt_d  = cnt_q + CW'(1);
          end
        end
        default: state_d = ARB;
      endcase
      if (m0_gnt) begin
        last_d = 1'b0;
      end else if (m1_gnt) begin
        last_d = 1'b1;
      end
    end
  end

  always_comb begin
    ram_A  = 32'h0;
    ram_D  = 32'h0;
    ram_WE = 1'b0;
    if (m1_gnt) begin
      ram_A  = m1_addr;
      ram_D  = m1_wdata;
      ram_WE = m1_we && in1;
    end else if (m0_gnt) begin
      ram_A  = m0_addr;
      ram_D  = m0_wdata;
      ram_WE = m0_we && in0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ARB;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      m0_rvalid <= 1'b0;
      m0_rdata  <= 32'h0;
      m0_err    <= 1'b0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= 32'h0;
      m1_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      m0_rvalid <= m0_gnt;
      m1_rvalid <= m1_gnt;
      // ram_Q is sampled at the grant edge, so reads see pre-write contents.
      if (m0_gnt) begin
        m0_rdata <= (!m0_we && in0) ? ram_Q : 32'h0;
        m0_err   <= !in0;
      end
      if (m1_gnt) begin
        m1_rdata <= (!m1_we && in1) ? ram_Q : 32'h0;
        m1_err   <= !in1;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a vector table for per-cycle grants and
// responses, plus hand sequences for forced lock release and async reset.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] ram_A, ram_D, ram_Q;
  logic        ram_WE;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];

  ram_arbiter #(.LEN(1024), .MAX_LOCK(16)) dut (
    .CLK(clk), .RST(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_A(ram_A), .ram_D(ram_D), .ram_WE(ram_WE), .ram_Q(ram_Q)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // RAM model: combinational read, write on rising edge.
  assign ram_Q = (ram_A < 32'd1024) ? mem[ram_A[9:0]] : 32'h0;
  always @(posedge clk) begin
    if (ram_WE && ram_A < 32'd1024) mem[ram_A[9:0]] <= ram_D;
  end

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        lk;
    logic        eg0, eg1, ewe;
    logic        ev0;
    logic [31:0] ed0;
    logic        ee0;
    logic        ev1;
    logic [31:0] ed1;
    logic        ee1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(
    input logic rs, input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
    input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1, input logic lk,
    input logic g0, input logic g1, input logic we,
    input logic v0, input logic [31:0] rd0, input logic e0,
    input logic v1, input logic [31:0] rd1, input logic e1);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.lk = lk;
    v.eg0 = g0; v.eg1 = g1; v.ewe = we;
    v.ev0 = v0; v.ed0 = rd0; v.ee0 = e0;
    v.ev1 = v1; v.ed1 = rd1; v.ee1 = e1;
    return v;
  endfunction

  function automatic logic [31:0] mi(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  // Scoreboard
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Driver
  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic lk);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_lock = lk;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = mi(i);
    mem[5] = 32'hA5A5_0001;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // single read
    tbl.push_back(row(0, 1,0,32'd5,0,      0,0,0,0,0,  1,0,0, 0,0,0,             0,0,0));
    tbl.push_back(row(0, 0,0,0,0,          0,0,0,0,0,  0,0,0, 1,32'hA5A5_0001,0, 0,0,0));
    // reset held across an edge while a write is requested: no grant, no write
    tbl.push_back(row(1, 1,1,32'd30,32'hFFFF_FFFF, 1,0,32'd6,0,0, 0,0,0, 0,0,0, 0,0,0));
    // contention: alternate m0, m1, ... starting with m0
    tbl.push_back(row(0, 1,0,32'd7,0, 1,0,32'd8,0,0, 1,0,0, 0,0,0,      0,0,0));
    tbl.push_back(row(0, 1,0,32'd7,0, 1,0,32'd8,0,0, 0,1,0, 1,mi(7),0,  0,0,0));
    tbl.push_back(row(0, 1,0,32'd7,0, 1,0,32'd8,0,0, 1,0,0, 0,0,0,      1,mi(8),0));
    tbl.push_back(row(0, 1,0,32'd7,0, 1,0,32'd8,0,0, 0,1,0, 1,mi(7),0,  0,0,0));
    tbl.push_back(row(0, 1,0,32'd7,0, 1,0,32'd8,0,0, 1,0,0, 0,0,0,      1,mi(8),0));
    tbl.push_back(row(0, 1,0,32'd7,0, 1,0,32'd8,0,0, 0,1,0, 1,mi(7),0,  0,0,0));
    // write / read-back / out of range
    tbl.push_back(row(0, 0,0,0,0, 1,1,32'd10,32'hDEAD_BEEF,0, 0,1,1, 0,0,0, 1,mi(8),0));
    tbl.push_back(row(0, 0,0,0,0, 1,0,32'd10,0,0,             0,1,0, 0,0,0, 1,0,0));
    tbl.push_back(row(0, 1,1,32'd1024,32'h1234,0,0,0,0,0,     1,0,0, 0,0,0, 1,32'hDEAD_BEEF,0));
    tbl.push_back(row(0, 0,0,0,0, 0,0,0,0,0,                  0,0,0, 1,0,1, 0,0,0));
    tbl.push_back(row(0, 0,0,0,0, 1,0,32'hFFFF_FFFF,0,0,      0,1,0, 0,0,0, 0,0,0));
    tbl.push_back(row(0, 1,0,32'd1023,0, 0,0,0,0,0,           1,0,0, 0,0,0, 1,0,1));
    tbl.push_back(row(0, 1,1,32'h405,32'h0BAD, 0,0,0,0,0,     1,0,0, 1,mi(1023),0, 0,0,0));
    tbl.push_back(row(0, 1,0,32'd5,0, 0,0,0,0,0,              1,0,0, 1,0,1, 0,0,0));
    tbl.push_back(row(0, 1,0,32'd30,0, 0,0,0,0,0,             1,0,0, 1,32'hA5A5_0001,0, 0,0,0));
    tbl.push_back(row(0, 0,0,0,0, 0,0,0,0,0,                  0,0,0, 1,mi(30),0, 0,0,0));
    // lock held 4 cycles, then dropped
    tbl.push_back(row(0, 1,0,32'd21,0, 1,0,32'd20,0,1, 0,1,0, 0,0,0, 0,0,0));
    tbl.push_back(row(0, 1,0,32'd21,0, 1,0,32'd20,0,1, 0,1,0, 0,0,0, 1,mi(20),0));
    tbl.push_back(row(0, 1,0,32'd21,0, 1,0,32'd20,0,1, 0,1,0, 0,0,0, 1,mi(20),0));
    tbl.push_back(row(0, 1,0,32'd21,0, 1,0,32'd20,0,1, 0,1,0, 0,0,0, 1,mi(20),0));
    tbl.push_back(row(0, 1,0,32'd21,0, 1,0,32'd20,0,0, 0,1,0, 0,0,0, 1,mi(20),0));
    tbl.push_back(row(0, 1,0,32'd21,0, 1,0,32'd20,0,0, 1,0,0, 0,0,0, 1,mi(20),0));
    tbl.push_back(row(0, 0,0,0,0, 0,0,0,0,0,              0,0,0, 1,mi(21),0, 0,0,0));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      rst = tbl[i].rst;
      drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
            tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, tbl[i].lk);
      @(negedge clk);
      chk($sformatf("row%0d m0_gnt", i), 32'(m0_gnt), 32'(tbl[i].eg0));
      chk($sformatf("row%0d m1_gnt", i), 32'(m1_gnt), 32'(tbl[i].eg1));
      chk($sformatf("row%0d ram_WE", i), 32'(ram_WE), 32'(tbl[i].ewe));
      chk($sformatf("row%0d m0_rvalid", i), 32'(m0_rvalid), 32'(tbl[i].ev0));
      chk($sformatf("row%0d m1_rvalid", i), 32'(m1_rvalid), 32'(tbl[i].ev1));
      if (tbl[i].ev0 || tbl[i].rst) begin
        chk($sformatf("row%0d m0_rdata", i), m0_rdata, tbl[i].ed0);
        chk($sformatf("row%0d m0_err", i), 32'(m0_err), 32'(tbl[i].ee0));
      end
      if (tbl[i].ev1 || tbl[i].rst) begin
        chk($sformatf("row%0d m1_rdata", i), m1_rdata, tbl[i].ed1);
        chk($sformatf("row%0d m1_err", i), 32'(m1_err), 32'(tbl[i].ee1));
      end
    end

    // Starvation bound: lock held forever, both requesting every cycle.
    begin
      logic pg0, pg1, eg0, eg1;
      pg0 = 1'b0;
      pg1 = 1'b0;
      for (int k = 0; k <= 18; k++) begin
        @(posedge clk);
        #1 drive(1, 0, 32'd21, 0, 1, 0, 32'd20, 0, 1);
        eg1 = (k <= 15) || (k == 18);
        eg0 = (k == 17);
        @(negedge clk);
        chk($sformatf("starve%0d m0_gnt", k), 32'(m0_gnt), 32'(eg0));
        chk($sformatf("starve%0d m1_gnt", k), 32'(m1_gnt), 32'(eg1));
        chk($sformatf("starve%0d m0_rvalid", k), 32'(m0_rvalid), 32'(pg0));
        chk($sformatf("starve%0d m1_rvalid", k), 32'(m1_rvalid), 32'(pg1));
        pg0 = eg0;
        pg1 = eg1;
      end
    end

    // Async reset between edges while locked with a response in flight.
    @(posedge clk);
    #2;
    chk("midlock m1_rvalid before reset", 32'(m1_rvalid), 32'd1);
    chk("midlock m1_rdata before reset", m1_rdata, mi(20));
    rst = 1'b1;
    #1;
    chk("async m0_gnt", 32'(m0_gnt), 32'd0);
    chk("async m1_gnt", 32'(m1_gnt), 32'd0);
    chk("async ram_WE", 32'(ram_WE), 32'd0);
    chk("async m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("async m1_rdata", m1_rdata, 32'd0);
    chk("async m0_rvalid", 32'(m0_rvalid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 0, 32'd7, 0, 1, 0, 32'd8, 0, 0);
    @(negedge clk);
    chk("post-reset tie m0_gnt", 32'(m0_gnt), 32'd1);
    chk("post-reset tie m1_gnt", 32'(m1_gnt), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post-reset next m1_gnt", 32'(m1_gnt), 32'd1);
    chk("post-reset m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("post-reset m0_rdata", m0_rdata, mi(7));

    // Report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
